// File: rtl/delay_line_mc.sv
// delay_line_mc -- multi-channel programmable delay line.
//
// Each channel has a circular buffer of MAX_DEPTH entries. All channels share
// one write pointer. The delay D is counted in valid beats. The output of the
// beat that writes sample n carries sample n-(D-1), and it appears one clock
// after that beat. Changing the delay to another legal value flushes priming:
// the fill counter restarts. An illegal delay value (0 or > MAX_DEPTH) is
// ignored and sets a sticky cfg_error flag.
//
// Optional feature: define DELAY_LINE_MC_SUM_EN to add sum_data. This output
// is the signed sum of all delayed channels and is registered with out_data.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   in_data holds one sample per channel this cycle
//   in_data    NUM_CHANNELS x DATA_SIZE samples, two's complement
//   enable     output gate (the buffer keeps running when enable is 0)
//   delay_sel  requested delay in beats, legal range 1..MAX_DEPTH
//   out_valid  out_data holds a valid delayed sample set
//   out_data   NUM_CHANNELS x FULL_SIZE sign-extended samples, 0 when not valid
//   sum_data   (DELAY_LINE_MC_SUM_EN only) signed sum of the delayed channels
//   cfg_error  sticky flag for an illegal delay request
module delay_line_mc #(
    parameter int DATA_SIZE    = 16,
    parameter int FULL_SIZE    = 20,
    parameter int NUM_CHANNELS = 4,
    parameter int MAX_DEPTH    = 8,
    localparam int DW          = $clog2(MAX_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [NUM_CHANNELS*DATA_SIZE-1:0]  in_data,
    input  logic                               enable,
    input  logic [DW-1:0]                      delay_sel,
    output logic                               out_valid,
    output logic [NUM_CHANNELS*FULL_SIZE-1:0]  out_data,
`ifdef DELAY_LINE_MC_SUM_EN
    output logic signed [FULL_SIZE+$clog2(NUM_CHANNELS)-1:0] sum_data,
`endif
    output logic                               cfg_error
);

    localparam int              PW       = $clog2(MAX_DEPTH);
    localparam int              IW       = DW + 1;
    localparam logic [DW-1:0]   MAX_D    = DW'(MAX_DEPTH);
    localparam logic [DW-1:0]   ONE_D    = DW'(1);
    localparam logic [PW-1:0]   LAST_PTR = PW'(MAX_DEPTH - 1);

    logic [PW-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]                      fill_q, fill_d;
    logic [DW-1:0]                      dly_q, dly_d;
    logic [DW-1:0]                      dly_eff, fill_eff;
    logic                               cfg_error_q, cfg_error_d;
    logic                               out_valid_q, out_valid_d;
    logic [NUM_CHANNELS*FULL_SIZE-1:0]  out_data_q, out_data_d;
    logic [NUM_CHANNELS*FULL_SIZE-1:0]  rd_flat;
    logic                               sel_legal, flush, primed, fire;
    logic [IW-1:0]                      ptr_x, back_x, idx_x;
    logic [PW-1:0]                      rd_idx;

`ifdef DELAY_LINE_MC_SUM_EN
    localparam int SW = FULL_SIZE + $clog2(NUM_CHANNELS);
    logic signed [FULL_SIZE-1:0] rd_chan [NUM_CHANNELS];
    logic signed [SW-1:0]        sum_all, sum_q;
`endif

    always_comb begin
        sel_legal   = (delay_sel != '0) && (delay_sel <= MAX_D);
        flush       = sel_legal && (delay_sel != dly_q);
        // In a flush cycle the new delay and an empty fill count already
        // apply, so a beat in that cycle counts as the first one afterwards.
        dly_eff     = flush ? delay_sel : dly_q;
        fill_eff    = flush ? '0 : fill_q;
        dly_d       = dly_eff;
        cfg_error_d = cfg_error_q | ~sel_legal;
        primed      = ({1'b0, fill_eff} + IW'(1)) >= {1'b0, dly_eff};
        fire        = in_valid & enable & primed;

        if (in_valid) begin
            fill_d   = (fill_eff == MAX_D) ? fill_eff : fill_eff + ONE_D;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end else begin
            fill_d   = fill_eff;
            wr_ptr_d = wr_ptr_q;
        end

        // Read index is (wr_ptr - (D-1)) mod MAX_DEPTH. The extra bit keeps
        // the wrap correct when MAX_DEPTH is not a power of two.
        ptr_x  = IW'(wr_ptr_q);
        back_x = IW'(dly_eff) - IW'(1);
        idx_x  = (ptr_x >= back_x) ? (ptr_x - back_x)
                                   : (ptr_x + IW'(MAX_DEPTH) - back_x);
        rd_idx = idx_x[PW-1:0];

        out_valid_d = fire;
        out_data_d  = fire ? rd_flat : '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            logic signed [DATA_SIZE-1:0] in_s;
            logic signed [FULL_SIZE-1:0] wr_ext;
            logic signed [FULL_SIZE-1:0] rd_s;
            logic [FULL_SIZE-1:0]        mem_q [MAX_DEPTH];

            assign in_s   = in_data[gi*DATA_SIZE +: DATA_SIZE];
            assign wr_ext = FULL_SIZE'(in_s);
            // D=1 means the sample being written now. Bypass the array so that
            // the read happens before the write in the same beat.
            assign rd_s   = (dly_eff == ONE_D) ? wr_ext : mem_q[rd_idx];
            assign rd_flat[gi*FULL_SIZE +: FULL_SIZE] = rd_s;
`ifdef DELAY_LINE_MC_SUM_EN
            assign rd_chan[gi] = rd_s;
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < MAX_DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                end else if (in_valid) begin
                    mem_q[wr_ptr_q] <= wr_ext;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            dly_q       <= ONE_D;
            cfg_error_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            dly_q       <= dly_d;
            cfg_error_q <= cfg_error_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_error = cfg_error_q;

`ifdef DELAY_LINE_MC_SUM_EN
    // The sum width has log2(NUM_CHANNELS) growth bits, so it cannot overflow.
    always_comb begin
        sum_all = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sum_all = sum_all + SW'(rd_chan[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= fire ? sum_all : '0;
        end
    end

    assign sum_data = sum_q;
`endif

endmodule
